// File: rtl/hazard_pkg.sv
// Shared decode constants and FSM encoding for the pipeline hazard sequencer.
// Field positions follow the 32-bit instruction word layout.
package hazard_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int AOP_HI = 6;
  localparam int AOP_LO = 2;

  localparam logic [1:0] RUN     = 2'b00;
  localparam logic [1:0] MD_WAIT = 2'b01;
  localparam logic [1:0] MD_DONE = 2'b10;

endpackage

// File: rtl/insn_decode_hz.sv
// Combinational decode of the fields the hazard logic needs from one latch.
// Instantiated once for FD and once for DX.
module insn_decode_hz
  import hazard_pkg::*;
(
  input  logic [31:0] insn_i,
  output logic        is_lw_o,
  output logic        is_mul_o,
  output logic        is_div_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o
);

  logic [4:0] op;
  logic [4:0] aop;
  logic       unused_bits;

  assign op   = insn_i[OP_HI:OP_LO];
  assign aop  = insn_i[AOP_HI:AOP_LO];
  assign rd_o = insn_i[RD_HI:RD_LO];
  assign rs_o = insn_i[RS_HI:RS_LO];
  assign rt_o = insn_i[RT_HI:RT_LO];

  assign is_lw_o  = (op == OP_LW);
  assign is_mul_o = (op == OP_ALU) && (aop == ALU_MUL);
  assign is_div_o = (op == OP_ALU) && (aop == ALU_DIV);

  assign unused_bits = ^{insn_i[11:7], insn_i[1:0]};

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush controller: load-use interlock, multdiv sequencing with
// timeout, XM redirect flush, and a saturating stall-cycle counter.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_insn,
  input  logic [31:0]      dx_insn,
  input  logic             xm_redirect,
  input  logic             md_ready,
  input  logic             md_exception,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             dx_bubble,
  output logic             xm_bubble,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             md_done,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WCW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(MD_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_set;

  logic       fd_lw, fd_mul, fd_div;
  logic [4:0] fd_rd, fd_rs, fd_rt;
  logic       dx_lw, dx_mul, dx_div;
  logic [4:0] dx_rd, dx_rs, dx_rt;
  logic       load_use, dx_md;
  logic       unused_sig;

  insn_decode_hz u_fd_dec (
    .insn_i   (fd_insn),
    .is_lw_o  (fd_lw),
    .is_mul_o (fd_mul),
    .is_div_o (fd_div),
    .rd_o     (fd_rd),
    .rs_o     (fd_rs),
    .rt_o     (fd_rt)
  );

  insn_decode_hz u_dx_dec (
    .insn_i   (dx_insn),
    .is_lw_o  (dx_lw),
    .is_mul_o (dx_mul),
    .is_div_o (dx_div),
    .rd_o     (dx_rd),
    .rs_o     (dx_rs),
    .rt_o     (dx_rt)
  );

  // md_exception only qualifies md_ready; X consumes it with the result
  assign unused_sig = ^{fd_lw, fd_mul, fd_div, fd_rd,
                        dx_rs, dx_rt, md_exception};

  assign dx_md    = dx_mul | dx_div;
  assign load_use = dx_lw && (dx_rd != 5'd0) &&
                    ((fd_rs == dx_rd) || (fd_rt == dx_rd));

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    tmo_set   = 1'b0;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    dx_en     = 1'b1;
    dx_bubble = 1'b0;
    xm_bubble = 1'b0;
    fd_flush  = 1'b0;
    dx_flush  = 1'b0;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    md_done   = 1'b0;
    // Held in reset: keep outputs quiet so no start pulse escapes
    if (reset) begin
      unique case (state_q)
        RUN: begin
          if (xm_redirect) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
          end else if (dx_md) begin
            ctrl_mult = dx_mul;
            ctrl_div  = dx_div;
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_bubble = 1'b1;
            state_d   = MD_WAIT;
            wcnt_d    = '0;
          end else if (load_use) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_bubble = 1'b1;
          end
        end
        MD_WAIT: begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          dx_en     = 1'b0;
          xm_bubble = 1'b1;
          if (md_ready) begin
            state_d = MD_DONE;
          end else if (wcnt_q == WLAST) begin
            tmo_set = 1'b1;
            state_d = MD_DONE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        MD_DONE: begin
          md_done = 1'b1;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!pc_en && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_q | tmo_set;
    end
  end

  assign md_timeout  = tmo_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: load-use, multdiv, redirect,
// timeout and asynchronous reset scenarios.
module tb_hazard_sequencer;

  logic        clock;
  logic        reset;
  logic [31:0] fd_insn, dx_insn;
  logic        xm_redirect, md_ready, md_exception;
  logic        pc_en, fd_en, dx_en, dx_bubble, xm_bubble;
  logic        fd_flush, dx_flush, ctrl_mult, ctrl_div, md_done;
  logic        md_timeout;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt;

  // {pc,fd,dx en, dx_bub, xm_bub, fd_fl, dx_fl, mult, div, done}
  localparam logic [9:0] E_RUN  = 10'b1110000000;
  localparam logic [9:0] E_LU   = 10'b0011000000;
  localparam logic [9:0] E_MD   = 10'b0000100000;
  localparam logic [9:0] E_MUL  = 10'b0000100100;
  localparam logic [9:0] E_DIV  = 10'b0000100010;
  localparam logic [9:0] E_RDR  = 10'b1110011000;
  localparam logic [9:0] E_DONE = 10'b1110000001;

  hazard_sequencer #(.MD_TIMEOUT(64), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .fd_insn      (fd_insn),
    .dx_insn      (dx_insn),
    .xm_redirect  (xm_redirect),
    .md_ready     (md_ready),
    .md_exception (md_exception),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .dx_en        (dx_en),
    .dx_bubble    (dx_bubble),
    .xm_bubble    (xm_bubble),
    .fd_flush     (fd_flush),
    .dx_flush     (dx_flush),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .md_done      (md_done),
    .md_timeout   (md_timeout),
    .stall_count  (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] aop);
    return {op, rd, rs, rt, 5'd0, aop, 2'b00};
  endfunction

  function automatic logic [9:0] outs();
    return {pc_en, fd_en, dx_en, dx_bubble, xm_bubble,
            fd_flush, dx_flush, ctrl_mult, ctrl_div, md_done};
  endfunction

  localparam logic [31:0] NOP = 32'h0;
  logic [31:0] MUL, DIV, LW5;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    dx_insn = MUL;
    fd_insn = NOP;
    #3;
    checks++;
    if (outs() !== E_RUN) begin
      errors++;
      $display("FAIL reset_outs got=%b want=%b", outs(), E_RUN);
    end
    checks++;
    if (md_timeout !== 1'b0 || stall_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs got=%b/%0d want=0/0", md_timeout, stall_count);
    end
    @(negedge clock);
    dx_insn = NOP;
    reset = 1'b1;
    exp_cnt = 16'd0;
    tick();
  endtask

  task automatic test_load_use();
    dx_insn = LW5;
    fd_insn = mk(5'b00000, 5'd1, 5'd5, 5'd2, 5'd0);
    #1;
    checks++;
    if (outs() !== E_LU) begin
      errors++;
      $display("FAIL lu_stall got=%b want=%b", outs(), E_LU);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    dx_insn = fd_insn;
    fd_insn = NOP;
    #1;
    checks++;
    if (outs() !== E_RUN) begin
      errors++;
      $display("FAIL lu_release got=%b want=%b", outs(), E_RUN);
    end
    checks++;
    if (stall_count !== exp_cnt) begin
      errors++;
      $display("FAIL lu_count got=%0d want=%0d", stall_count, exp_cnt);
    end
  endtask

  task automatic test_no_stall();
    dx_insn = mk(5'b01000, 5'd0, 5'd1, 5'd2, 5'd0);
    fd_insn = mk(5'b00000, 5'd1, 5'd0, 5'd0, 5'd0);
    #1;
    checks++;
    if (outs() !== E_RUN) begin
      errors++;
      $display("FAIL lu_r0 got=%b want=%b", outs(), E_RUN);
    end
    dx_insn = LW5;
    fd_insn = mk(5'b00000, 5'd1, 5'd6, 5'd7, 5'd0);
    #1;
    checks++;
    if (outs() !== E_RUN) begin
      errors++;
      $display("FAIL lu_other_regs got=%b want=%b", outs(), E_RUN);
    end
    fd_insn = mk(5'b00000, 5'd1, 5'd6, 5'd5, 5'd0);
    #1;
    checks++;
    if (outs() !== E_LU) begin
      errors++;
      $display("FAIL lu_rt got=%b want=%b", outs(), E_LU);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    dx_insn = NOP;
    fd_insn = NOP;
    #1;
    checks++;
    if (stall_count !== exp_cnt) begin
      errors++;
      $display("FAIL lu_rt_count got=%0d want=%0d", stall_count, exp_cnt);
    end
  endtask

  task automatic test_multiply();
    logic [9:0] want;
    dx_insn = MUL;
    fd_insn = MUL;
    md_ready = 1'b0;
    #1;
    checks++;
    if (outs() !== E_MUL) begin
      errors++;
      $display("FAIL mul_start got=%b want=%b", outs(), E_MUL);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      xm_redirect = (i == 2);
      md_ready = (i == 5);
      #1;
      want = E_MD;
      checks++;
      if (outs() !== want) begin
        errors++;
        $display("FAIL mul_wait%0d got=%b want=%b", i, outs(), want);
      end
    end
    xm_redirect = 1'b0;
    tick();
    exp_cnt = exp_cnt + 16'd6;
    md_ready = 1'b0;
    #1;
    checks++;
    if (outs() !== E_DONE) begin
      errors++;
      $display("FAIL mul_done got=%b want=%b", outs(), E_DONE);
    end
    checks++;
    if (stall_count !== exp_cnt) begin
      errors++;
      $display("FAIL mul_count got=%0d want=%0d", stall_count, exp_cnt);
    end
    tick();
    fd_insn = NOP;
    #1;
    checks++;
    if (outs() !== E_MUL) begin
      errors++;
      $display("FAIL b2b_start got=%b want=%b", outs(), E_MUL);
    end
    tick();
    md_ready = 1'b1;
    #1;
    checks++;
    if (outs() !== E_MD) begin
      errors++;
      $display("FAIL b2b_wait got=%b want=%b", outs(), E_MD);
    end
    tick();
    exp_cnt = exp_cnt + 16'd2;
    md_ready = 1'b0;
    #1;
    checks++;
    if (outs() !== E_DONE) begin
      errors++;
      $display("FAIL b2b_done got=%b want=%b", outs(), E_DONE);
    end
    tick();
    dx_insn = NOP;
    #1;
    checks++;
    if (outs() !== E_RUN || stall_count !== exp_cnt) begin
      errors++;
      $display("FAIL b2b_run got=%b/%0d want=%b/%0d",
               outs(), stall_count, E_RUN, exp_cnt);
    end
  endtask

  task automatic test_redirect();
    dx_insn = DIV;
    xm_redirect = 1'b1;
    #1;
    checks++;
    if (outs() !== E_RDR) begin
      errors++;
      $display("FAIL rdr_flush got=%b want=%b", outs(), E_RDR);
    end
    tick();
    xm_redirect = 1'b0;
    #1;
    checks++;
    if (outs() !== E_DIV) begin
      errors++;
      $display("FAIL rdr_div_start got=%b want=%b", outs(), E_DIV);
    end
    tick();
    md_ready = 1'b1;
    #1;
    tick();
    md_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd2;
    #1;
    checks++;
    if (outs() !== E_DONE) begin
      errors++;
      $display("FAIL div_done got=%b want=%b", outs(), E_DONE);
    end
    tick();
    dx_insn = NOP;
    #1;
    checks++;
    if (stall_count !== exp_cnt) begin
      errors++;
      $display("FAIL div_count got=%0d want=%0d", stall_count, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    int bad;
    dx_insn = MUL;
    md_ready = 1'b0;
    #1;
    tick();
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (outs() !== E_MD || md_timeout !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tmo_wait got=%0d bad cycles want=0", bad);
    end
    exp_cnt = exp_cnt + 16'd65;
    checks++;
    if (outs() !== E_DONE || md_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_done got=%b/%b want=%b/1", outs(), md_timeout, E_DONE);
    end
    checks++;
    if (stall_count !== exp_cnt) begin
      errors++;
      $display("FAIL tmo_count got=%0d want=%0d", stall_count, exp_cnt);
    end
    tick();
    dx_insn = NOP;
    tick();
    tick();
    checks++;
    if (md_timeout !== 1'b1 || outs() !== E_RUN) begin
      errors++;
      $display("FAIL tmo_sticky got=%b/%b want=1/%b", md_timeout, outs(), E_RUN);
    end
  endtask

  task automatic test_timeout_ready();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (md_timeout !== 1'b0 || stall_count !== 16'd0) begin
      errors++;
      $display("FAIL tmo_clear got=%b/%0d want=0/0", md_timeout, stall_count);
    end
    @(negedge clock);
    reset = 1'b1;
    exp_cnt = 16'd0;
    dx_insn = MUL;
    tick();
    for (int i = 0; i < 63; i++) tick();
    md_ready = 1'b1;
    #1;
    checks++;
    if (outs() !== E_MD) begin
      errors++;
      $display("FAIL tmo_rdy_last got=%b want=%b", outs(), E_MD);
    end
    tick();
    md_ready = 1'b0;
    #1;
    checks++;
    if (outs() !== E_DONE || md_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_rdy_done got=%b/%b want=%b/0", outs(), md_timeout, E_DONE);
    end
    tick();
    dx_insn = NOP;
    #1;
    checks++;
    if (stall_count !== 16'd65 || md_timeout !== 1'b0) begin
      errors++;
      $display("FAIL tmo_rdy_count got=%0d/%b want=65/0", stall_count, md_timeout);
    end
  endtask

  task automatic test_reset_mid_wait();
    dx_insn = MUL;
    #1;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== E_RUN || stall_count !== 16'd0 || md_timeout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got=%b/%0d/%b want=%b/0/0",
               outs(), stall_count, md_timeout, E_RUN);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== E_MUL) begin
      errors++;
      $display("FAIL rst_mid_run got=%b want=%b", outs(), E_MUL);
    end
    dx_insn = NOP;
    #1;
    tick();
    checks++;
    if (outs() !== E_RUN || stall_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_after got=%b/%0d want=%b/0", outs(), stall_count, E_RUN);
    end
  endtask

  initial begin
    MUL = mk(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00110);
    DIV = mk(5'b00000, 5'd4, 5'd1, 5'd2, 5'b00111);
    LW5 = mk(5'b01000, 5'd5, 5'd9, 5'd0, 5'd0);
    fd_insn = NOP;
    dx_insn = NOP;
    xm_redirect = 1'b0;
    md_ready = 1'b0;
    md_exception = 1'b0;
    exp_cnt = 16'd0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_multiply();
    test_redirect();
    test_timeout();
    test_timeout_ready();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central stall/flush controller for the 5-stage pipeline (F, D, X, M, W); drives latch enables, bubble inserts and flushes.
- Combines three hazard sources:
  - load-use interlock between the FD and DX instructions;
  - multi-cycle multiply/divide sequencing: start pulse, wait for ready, timeout;
  - taken-branch/jump flush resolved in XM.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MD_TIMEOUT, 64: max cycles waiting for multdiv ready before abort.
- CNT_W, 16: width of stall_count.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- fd_insn  in  32  instruction in FD latch
- dx_insn  in  32  instruction in DX latch
- xm_redirect  in  1  taken branch/jump resolved in XM this cycle
- md_ready  in  1  multdiv result valid (data_resultRDY)
- md_exception  in  1  multdiv exception, qualifies md_ready
- pc_en  out  1  PC register write enable
- fd_en  out  1  FD latch write enable
- dx_en  out  1  DX latch write enable
- dx_bubble  out  1  load nop into DX instead of FD contents
- xm_bubble  out  1  load nop into XM instead of X results
- fd_flush  out  1  clear FD to nop
- dx_flush  out  1  clear DX to nop
- ctrl_mult  out  1  one-cycle multiply start pulse
- ctrl_div  out  1  one-cycle divide start pulse
- md_done  out  1  one-cycle pulse: multdiv result captured (X may advance)
- md_timeout  out  1  sticky flag, set on timeout, cleared only by reset
- stall_count  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Instruction fields:
  - opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
  - lw = opcode 01000.
  - mul = opcode 00000 & aluop 00110.
  - div = opcode 00000 & aluop 00111.
- Load-use condition: dx is lw, dx rd != 0, and (fd rs == dx rd or fd rt == dx rd).
- Reset (reset low, async): state=RUN, all enables 1, all bubble/flush/pulse outputs 0, md_timeout=0, stall_count=0, wait counter=0.
- FSM states: RUN, MD_WAIT, MD_DONE.
- RUN, priority top-down:
  1. xm_redirect: fd_flush=dx_flush=1 and all enables=1. No multdiv start even if dx holds mul/div. Stay in RUN.
  2. dx is mul/div: pulse ctrl_mult or ctrl_div for this cycle only. pc_en=fd_en=dx_en=0, xm_bubble=1. Go to MD_WAIT and clear the wait counter.
  3. Load-use: pc_en=fd_en=0, dx_bubble=1. Stay in RUN; the hazard clears the next cycle as lw advances.
  4. Otherwise all enables=1 and all bubbles/flushes=0.
- MD_WAIT:
  - pc_en=fd_en=dx_en=0, xm_bubble=1. xm_redirect is ignored (XM holds a bubble).
  - md_ready=1 goes to MD_DONE.
  - Otherwise the counter increments. When the counter reaches MD_TIMEOUT-1 without ready, set md_timeout and go to MD_DONE.
  - md_ready and the timeout in the same cycle: ready wins and md_timeout is not set.
- MD_DONE (exactly 1 cycle):
  - md_done=1, pc_en=fd_en=dx_en=1, xm_bubble=0, so X results advance to XM. Then go to RUN.
  - A load-use from the newly latched DX is evaluated normally on the next RUN cycle.
- Back-to-back mul in FD behind a mul in DX: the second mul starts in the RUN cycle after MD_DONE.
- stall_count increments each cycle pc_en=0 and saturates at all-ones.
- All outputs are combinational from state plus inputs, except md_timeout and stall_count, which are registered.
- Reset mid-MD_WAIT returns to RUN immediately and issues no pulse.

Decomposition:
- Shared package hazard_pkg holds:
  - opcode constants OP_ALU=00000 and OP_LW=01000;
  - ALU op constants ALU_MUL=00110 and ALU_DIV=00111;
  - field bit-position constants;
  - state encoding RUN=2'b00, MD_WAIT=2'b01, MD_DONE=2'b10.
- One sub-module, insn_decode_hz: purely combinational decode of is_lw, is_mul, is_div, rd, rs, rt; instantiated twice (fd, dx).

Test Plan:
- Load-use: dx=lw r5; fd=add r1,r5,r2 → one cycle with pc_en=0, fd_en=0, dx_bubble=1; next cycle all enables 1; stall_count=1.
- lw r0 in dx and fd reads r0 → no stall; lw r5 with fd using only r6,r7 → no stall.
- Multiply: mul in dx, md_ready asserted 5 cycles after the ctrl_mult pulse → ctrl_mult high 1 cycle, 6 stall cycles, md_done pulse, then RUN; stall_count=6.
- Redirect precedence: xm_redirect=1 with div in dx → fd_flush=dx_flush=1, ctrl_div=0, state stays RUN.
- Timeout: mul started, md_ready held 0 → md_timeout set after 64 MD_WAIT cycles, md_done pulses, flag stays set until reset; ready in the timeout cycle → no flag.
- Reset: assert reset mid-MD_WAIT → outputs return to reset values asynchronously, state=RUN, stall_count=0.
